// File: rtl/sid_ext_filter_pkg.sv
// Shared SID sample types plus the saturation helpers and defaults used by the
// external RC output stage.
package sid;

   typedef logic signed [23:0] s24_t;
   typedef logic signed [31:0] s32_t;
   typedef logic signed [15:0] s16_t;

   localparam s16_t EXT_LP_W0T_LSL17_DEFAULT = 16'sd13107;
   localparam int   EXT_HP_SHIFT_DEFAULT     = 17;

   // Sign-extend an s24 into the 41-bit domain sat24 works in.
   function automatic logic signed [40:0] sx41(input s24_t v);
      return {{17{v[23]}}, v};
   endfunction

   function automatic s24_t sat24(input logic signed [40:0] v);
      if (v > 41'sd8388607) return 24'sh7FFFFF;
      if (v < -41'sd8388608) return 24'sh800000;
      return v[23:0];
   endfunction

endpackage

// File: rtl/sid_ext_filter_if.sv
// Output sample register handshake between the external filter and the audio
// serializer. A sample moves when valid and ready are both 1 at a clk edge.
interface sid_ext_filter_if;
   import sid::*;

   s24_t sample_o;
   logic sample_valid_o;
   logic sample_ready_i;
   logic overrun_o;

   modport master (output sample_o, output sample_valid_o, output overrun_o,
                   input sample_ready_i);
   modport slave  (input sample_o, input sample_valid_o, input overrun_o,
                   output sample_ready_i);
endinterface

// File: rtl/sid_ext_filter_muladd.sv
// Shared registered multiply-accumulate: o <= c +/- a*b when en is high.
module muladd
   import sid::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s,
   input  s32_t c,
   input  s16_t a,
   input  s16_t b,
   output s32_t o
);
   s32_t o_q, o_d, prod;

   always_comb begin
      prod = s32_t'(a) * s32_t'(b);
      o_d  = o_q;
      if (en) o_d = s ? (c - prod) : (c + prod);
   end

   always_ff @(posedge clk) begin
      if (rst) o_q <= '0;
      else     o_q <= o_d;
   end

   assign o = o_q;
endmodule

// File: rtl/sid_ext_filter.sv
// C64 external output stage: 1-pole low-pass then 1-pole DC-blocking high-pass,
// one sample per 8-stage sequencer round, result held in a valid/ready register.
module sid_ext_filter
   import sid::*;
#(
   parameter s16_t LP_W0T_LSL17 = EXT_LP_W0T_LSL17_DEFAULT,
   parameter int   HP_SHIFT     = EXT_HP_SHIFT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       stage,
   input  logic             bypass_i,
   input  s24_t             audio_i,
   sid_ext_filter_if.master out_if
);
   localparam int VDC_W = 24 + HP_SHIFT;

   s24_t x_q, x_d, vlp_q, vlp_d, sample_q, sample_d;
   logic signed [VDC_W-1:0] vdc_q, vdc_d;
   logic pend_q, pend_d, valid_q, valid_d, overrun_q, overrun_d;

   s24_t lp_diff, lp_step, vdc_int, y;
   s16_t mac_b;
   s32_t mac_o;
   logic mac_en, load;
   logic signed [VDC_W:0] hp_delta, hp_step;
   logic unused_bits;

   muladd u_muladd (
      .clk(clk), .rst(rst), .en(mac_en), .s(1'b0), .c(32'sd0),
      .a(LP_W0T_LSL17), .b(mac_b), .o(mac_o)
   );

   always_comb begin
      lp_diff  = sat24(sx41(x_q) - sx41(vlp_q));
      mac_b    = lp_diff[23:8];
      mac_en   = (stage == 3'd1) && pend_q;
      lp_step  = {mac_o[31], mac_o[31:9]};
      vdc_int  = vdc_q[VDC_W-1:HP_SHIFT];
      y        = bypass_i ? x_q : sat24(sx41(vlp_q) - sx41(vdc_int));
      // vdc has HP_SHIFT fraction bits, so the integer vlp is aligned by a left shift.
      hp_delta = {vlp_q[23], vlp_q, {HP_SHIFT{1'b0}}} - {vdc_q[VDC_W-1], vdc_q};
      hp_step  = hp_delta >>> HP_SHIFT;
      load     = (stage == 3'd3) && pend_q;

      x_d       = x_q;
      vlp_d     = vlp_q;
      vdc_d     = vdc_q;
      pend_d    = pend_q;
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      case (stage)
         3'd0: begin
            x_d    = audio_i;
            pend_d = 1'b1;
         end
         3'd2: if (pend_q) vlp_d = sat24(sx41(vlp_q) + sx41(lp_step));
         default: ;
      endcase

      // A load always wins over a transfer in the same cycle, and is not an overrun.
      if (load) begin
         vdc_d    = vdc_q + hp_step[VDC_W-1:0];
         sample_d = y;
         valid_d  = 1'b1;
         pend_d   = 1'b0;
         if (valid_q && !out_if.sample_ready_i) overrun_d = 1'b1;
      end else if (valid_q && out_if.sample_ready_i) begin
         valid_d = 1'b0;
      end
   end

   assign unused_bits = ^{lp_diff[7:0], mac_o[8:0], hp_step[VDC_W]};

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q       <= '0;
         vlp_q     <= '0;
         vdc_q     <= '0;
         pend_q    <= 1'b0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         vlp_q     <= vlp_d;
         vdc_q     <= vdc_d;
         pend_q    <= pend_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_if.sample_o       = sample_q;
   assign out_if.sample_valid_o = valid_q;
   assign out_if.overrun_o      = overrun_q;
endmodule

// File: tb/tb_sid_ext_filter.sv
// Directed plus randomized bench for sid_ext_filter against an arithmetic
// reference model of the low-pass / DC-block chain and the output register.
module tb_sid_ext_filter;
   import sid::*;

   localparam int HPS = 8;

   logic clk = 1'b0;
   logic rst;
   logic [2:0] stage;
   logic bypass_i;
   s24_t audio_i;

   sid_ext_filter_if bus ();

   sid_ext_filter #(.LP_W0T_LSL17(16'sd13107), .HP_SHIFT(HPS)) dut (
      .clk(clk), .rst(rst), .stage(stage), .bypass_i(bypass_i),
      .audio_i(audio_i), .out_if(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state: integer-valued filter state and pending outputs.
   longint m_x = 0, m_vlp = 0, m_vdc = 0, m_last = 0;
   bit m_pend = 1'b0, m_over = 1'b0;
   logic [23:0] exp_q[$];

   function automatic longint clamp24(input longint v);
      if (v > 64'sd8388607) return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clk: drive stage/ready, advance the model across the edge, then compare.
   // rmode: 0 ready low, 1 ready high, 2 random, 3 high only at stage 3.
   task automatic cyc(input logic [2:0] st, input int rmode);
      logic rdy;
      bit load;
      longint diff, y;
      rdy = (rmode == 1) || (rmode == 2 && $urandom_range(0, 1) == 1) ||
            (rmode == 3 && st == 3'd3);
      stage = st;
      bus.sample_ready_i = rdy;
      load = 1'b0;
      if (rst) begin
         m_x = 0; m_vlp = 0; m_vdc = 0; m_pend = 1'b0; m_over = 1'b0;
         exp_q.delete();
      end else begin
         if (rdy && exp_q.size() != 0) begin
            chk("xfer_sample", bus.sample_o, exp_q[0]);
            void'(exp_q.pop_front());
         end
         case (st)
            3'd0: begin
               m_x = longint'(audio_i);
               m_pend = 1'b1;
            end
            3'd2: if (m_pend) begin
               diff = clamp24(m_x - m_vlp);
               m_vlp = clamp24(m_vlp + ((64'sd13107 * (diff >>> 8)) >>> 9));
            end
            3'd3: if (m_pend) begin
               y = bypass_i ? m_x : clamp24(m_vlp - (m_vdc >>> HPS));
               m_vdc = m_vdc + (((m_vlp <<< HPS) - m_vdc) >>> HPS);
               if (exp_q.size() != 0) begin
                  m_over = 1'b1;
                  exp_q.delete();
               end
               exp_q.push_back(y[23:0]);
               m_last = y;
               m_pend = 1'b0;
               load = 1'b1;
            end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      chk1("valid", bus.sample_valid_o, exp_q.size() != 0);
      chk1("overrun", bus.overrun_o, m_over);
      if (load) chk("load_sample", bus.sample_o, exp_q[$]);
   endtask

   task automatic stages(input int from, input int to, input int rmode);
      for (int s = from; s <= to; s++) cyc(3'(s), rmode);
   endtask

   s24_t dc_v;
   int dc_abs;

   initial begin
      rst = 1'b1; stage = 3'd0; bypass_i = 1'b0; audio_i = '0;
      bus.sample_ready_i = 1'b0;
      stages(0, 7, 0);
      rst = 1'b0;
      chk("reset_sample", bus.sample_o, 24'h000000);
      chk1("reset_valid", bus.sample_valid_o, 1'b0);
      chk1("reset_overrun", bus.overrun_o, 1'b0);

      // Reset held three clocks starting mid-round at stage 2.
      audio_i = s24_t'($urandom);
      stages(0, 1, 1);
      rst = 1'b1;
      stages(2, 4, 1);
      rst = 1'b0;
      chk("midrst_sample", bus.sample_o, 24'h000000);
      chk1("midrst_valid", bus.sample_valid_o, 1'b0);
      stages(5, 7, 1);

      // Low-pass step response, first round after reset.
      audio_i = 24'h100000;
      stages(0, 3, 1);
      chk("lp_step_sample", bus.sample_o, 24'd104856);
      chk1("lp_step_valid", bus.sample_valid_o, 1'b1);
      stages(4, 7, 1);

      // Random audio, random ready, bypass toggling every clk.
      for (int r = 0; r < 40; r++) begin
         audio_i = s24_t'($urandom);
         for (int s = 0; s < 8; s++) begin
            bypass_i = 1'($urandom_range(0, 1));
            cyc(3'(s), 2);
         end
      end
      bypass_i = 1'b0;

      // Reset at stage 0, round entered at stage 1 must produce nothing.
      rst = 1'b1;
      cyc(3'd0, 0);
      rst = 1'b0;
      audio_i = s24_t'($urandom);
      stages(1, 7, 0);
      chk1("midentry_valid", bus.sample_valid_o, 1'b0);

      // Overrun: two loads with ready low.
      audio_i = 24'h050000;
      stages(0, 7, 0);
      audio_i = 24'hF00000;
      stages(0, 3, 0);
      chk1("ovr_set", bus.overrun_o, 1'b1);
      chk("ovr_second_sample", bus.sample_o, 24'(m_last));
      cyc(3'd4, 1);
      chk1("ovr_valid_drop", bus.sample_valid_o, 1'b0);
      chk1("ovr_sticky", bus.overrun_o, 1'b1);
      stages(5, 7, 0);

      // Transfer and load in the same cycle.
      rst = 1'b1;
      cyc(3'd0, 0);
      rst = 1'b0;
      stages(1, 7, 0);
      audio_i = 24'h123456;
      stages(0, 7, 0);
      audio_i = 24'hE54321;
      stages(0, 2, 0);
      cyc(3'd3, 3);
      chk1("simul_valid", bus.sample_valid_o, 1'b1);
      chk1("simul_overrun", bus.overrun_o, 1'b0);
      chk("simul_sample", bus.sample_o, 24'(m_last));
      stages(4, 7, 0);

      // Bypass passes the raw sample.
      bypass_i = 1'b1;
      audio_i = -24'sd5;
      stages(0, 3, 1);
      chk("bypass_sample", bus.sample_o, 24'hFFFFFB);
      stages(4, 7, 1);
      bypass_i = 1'b0;

      // Full-scale alternation must saturate, never wrap.
      for (int r = 0; r < 20; r++) begin
         audio_i = (r % 2 == 0) ? 24'h7FFFFF : 24'h800000;
         stages(0, 7, 2);
      end

      // DC block on a constant input.
      rst = 1'b1;
      cyc(3'd0, 1);
      rst = 1'b0;
      stages(1, 7, 1);
      audio_i = 24'h100000;
      for (int r = 0; r < 2000; r++) stages(0, 7, 1);
      dc_v = bus.sample_o;
      dc_abs = (dc_v < 0) ? -int'(dc_v) : int'(dc_v);
      chk1("dc_small", dc_abs < 2048, 1'b1);
      chk1("dc_overrun", bus.overrun_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
